// File: rtl/ones_detect_pkg.sv
// rtl/ones_detect_pkg.sv - shared state encoding and default widths for the consecutive-ones detector
package ones_detect_pkg;

    localparam int CNT_W = 4;
    localparam int EVT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_MATCH = 2'b10,
        S_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/ones_run_counter.sv
// rtl/ones_run_counter.sv - saturating up-counter with clear, increment and limit
module ones_run_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         hit
);

    assign hit = (count == limit);

    // clear wins over inc; once at the limit the count holds instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !hit) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ones_detect_ctrl.sv
// rtl/ones_detect_ctrl.sv - start/stop sequenced consecutive-ones detector with event quota
module ones_detect_ctrl #(
    parameter int CNT_W = ones_detect_pkg::CNT_W,
    parameter int EVT_W = ones_detect_pkg::EVT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [EVT_W-1:0] cfg_evt,
    input  logic             x_in,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] run_cnt,
    output logic [EVT_W-1:0] evt_cnt,
    output logic             y,
    output logic             busy,
    output logic             done
);

    import ones_detect_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] len_q;
    logic [EVT_W-1:0] evt_q;

    logic latch_cfg;
    logic run_clr;
    logic run_inc;
    logic run_hit;
    logic evt_clr;
    logic evt_inc;
    logic evt_hit;
    logic run_reach;
    logic quota_met;

    // the next 1 lands exactly on the threshold
    assign run_reach = (({1'b0, run_cnt} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, len_q});
    assign quota_met = (evt_q != '0) && (evt_cnt == evt_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // a zero threshold would never match, so it is stored as one
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
            evt_q <= '0;
        end else if (latch_cfg) begin
            len_q <= (cfg_len == '0) ? CNT_W'(1) : cfg_len;
            evt_q <= cfg_evt;
        end
    end

    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        run_clr   = 1'b0;
        run_inc   = 1'b0;
        evt_clr   = 1'b0;
        evt_inc   = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            run_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        latch_cfg = 1'b1;
                        run_clr   = 1'b1;
                        evt_clr   = 1'b1;
                        state_d   = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (x_in) begin
                        run_inc = 1'b1;
                        if (run_reach) begin
                            evt_inc = !evt_hit;
                            state_d = S_MATCH;
                        end
                    end else begin
                        run_clr = 1'b1;
                    end
                end
                S_MATCH: begin
                    if (x_in) begin
                        run_inc = !run_hit;
                    end else begin
                        run_clr = 1'b1;
                        state_d = quota_met ? S_DONE : S_ARMED;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_clr = 1'b1;
                end
            endcase
        end
    end

    ones_run_counter #(.W(CNT_W)) u_run_cnt (
        .clock (clock),
        .reset (reset),
        .clear (run_clr),
        .inc   (run_inc),
        .limit (len_q),
        .count (run_cnt),
        .hit   (run_hit)
    );

    ones_run_counter #(.W(EVT_W)) u_evt_cnt (
        .clock (clock),
        .reset (reset),
        .clear (evt_clr),
        .inc   (evt_inc),
        .limit ({EVT_W{1'b1}}),
        .count (evt_cnt),
        .hit   (evt_hit)
    );

    assign state_out = state_q;
    assign y         = (state_q == S_MATCH);
    assign busy      = (state_q == S_ARMED) || (state_q == S_MATCH);
    assign done      = (state_q == S_DONE);

endmodule

// File: doc/ones_detect_ctrl.md
Name: ones_detect_ctrl

Overview:
Controller that sequences a programmable consecutive-ones detector on a serial input x_in. Software-style start/stop control arms the detector with a run-length threshold and an event quota. It counts qualifying runs and reports completion. It is a Moore FSM and sits between the serial input source and the status/interrupt logic.

Parameters:
CNT_W, 4, width of run-length threshold and run counter (max threshold 2^CNT_W-1)
EVT_W, 8, width of event quota and event counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  arm request; sampled in IDLE or DONE
stop  input  1  abort request; highest priority
cfg_len  input  CNT_W  consecutive-ones threshold; latched on accepted start
cfg_evt  input  EVT_W  number of runs before DONE; 0 = unlimited; latched on accepted start
x_in  input  1  serial data bit, sampled each rising edge
state_out  output  2  current FSM state encoding
run_cnt  output  CNT_W  current consecutive-ones count
evt_cnt  output  EVT_W  qualifying runs counted since last start
y  output  1  Moore detect flag, high in MATCH
busy  output  1  high in ARMED or MATCH
done  output  1  high in DONE

Behaviour:
- One clock. Reset is asynchronous and active-low: reset==0 forces all state immediately.
- Reset values: state IDLE, run_cnt 0, evt_cnt 0, latched len/evt 0, y 0, busy 0, done 0.
- States and encoding: IDLE=2'b00, ARMED=2'b01, MATCH=2'b10, DONE=2'b11. All outputs decode from registered state only (Moore).
- Priority on each edge: stop > start > x_in.
- IDLE:
  - start=1 latches cfg_len (0 is stored as 1) and cfg_evt, clears run_cnt and evt_cnt, then goes to ARMED.
  - x_in is ignored.
- ARMED:
  - x_in=1: run_cnt+1. If run_cnt+1 == len_q, go to MATCH and increment evt_cnt on the same edge.
  - x_in=0: run_cnt=0, stay in ARMED.
  - start is ignored.
- MATCH:
  - y=1. x_in=1 keeps MATCH; run_cnt saturates at len_q; no further evt increment. One event per run, however long the run is.
  - x_in=0: run_cnt=0. Go to DONE if evt_q!=0 and evt_cnt==evt_q, else go to ARMED.
- DONE:
  - done=1 and counters hold.
  - start=1 re-latches config, clears counters, goes to ARMED.
- stop=1 in any state: next state IDLE, run_cnt=0, evt_cnt retained for readout.
- Saturation: evt_cnt saturates at 2^EVT_W-1 and never wraps. With evt_q=0 the FSM never enters DONE.
- Latency: with len_q=3, x_in high at three consecutive edges gives MATCH (y=1) in the cycle after the third edge. The first 1 counts only if sampled while already in ARMED; the start edge does not sample x_in.
- Simultaneous events:
  - stop and start together: stop wins.
  - The edge that reaches the threshold in ARMED increments evt_cnt exactly once.
- Reset mid-run aborts immediately. No partial event is retained.
- Default/illegal state recovers to IDLE.

Decomposition:
- Shared package ones_detect_pkg holds:
  - state localparams S_IDLE, S_ARMED, S_MATCH, S_DONE
  - the 2-bit state typedef
  - default widths CNT_W and EVT_W
- One sub-module, ones_run_counter: a saturating counter with clear/increment/limit inputs and a hit output. It is instantiated for run_cnt; evt_cnt uses the same module with limit=all-ones.

Test Plan:
- Reset during activity: drive reset=0 mid-MATCH -> immediately state_out=00, y=0, busy=0, run_cnt=0, evt_cnt=0.
- cfg_len=3, cfg_evt=0, start; x_in=1,1,0,1,1,1,1,0 -> y high only after the 6th sample, stays high through the 7th, falls after the 8th (0); evt_cnt=1, run_cnt returns to 0.
- cfg_len=2, cfg_evt=2, start; x_in=1,1,0,1,1,0 -> MATCH twice, DONE entered after the 6th edge, done=1, evt_cnt=2; a further x_in=1 stream leaves evt_cnt at 2.
- cfg_len=0, start; x_in=1 -> MATCH after the first sample (threshold treated as 1), evt_cnt=1.
- In ARMED with run_cnt=2, assert stop and start together -> IDLE next edge, run_cnt=0, evt_cnt held; start alone next cycle -> ARMED, evt_cnt=0.
- cfg_evt=0, EVT_W=2; five separate runs of len_q ones -> evt_cnt saturates at 3, never DONE.
